// File: rtl/aes_inv_round_engine_if.sv
// Handshake/bus bundle for aes_inv_round_engine.
//   in_valid/in_ready/text_in     : ciphertext block input
//   key_idx/round_key             : lookup into an external expanded-key store
//   out_valid/out_ready/text_out  : plaintext block output
// master: the source/sink/key-store side. slave: the engine.
interface aes_inv_round_engine_if #(
    parameter int unsigned IDX_W = 4
) ();
    logic             in_valid;
    logic             in_ready;
    logic [127:0]     text_in;
    logic [IDX_W-1:0] key_idx;
    logic [127:0]     round_key;
    logic             out_valid;
    logic             out_ready;
    logic [127:0]     text_out;

    modport master (
        output in_valid, text_in, round_key, out_ready,
        input  in_ready, key_idx, out_valid, text_out
    );

    modport slave (
        input  in_valid, text_in, round_key, out_ready,
        output in_ready, key_idx, out_valid, text_out
    );
endinterface

// File: rtl/aes_inv_round_engine.sv
// Iterative AES inverse cipher: one shared inverse-round datapath, one round per clock.
// Ports:
//   Clk      : clock, rising edge
//   Reset_n  : asynchronous active-low reset
//   flush    : synchronous abort back to idle (priority over every transition)
//   bus      : aes_inv_round_engine_if.slave (input/output handshakes, key store lookup)
//   busy     : high while rounds are being computed
// Block byte k lives at bits [127-8k -: 8]; row k%4, column k/4.
module aes_inv_round_engine #(
    parameter int unsigned KEY_BITS = 128,
    parameter int unsigned IDX_W    = 4
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic                  flush,
    aes_inv_round_engine_if.slave bus,
    output logic                  busy
);

    localparam int unsigned NR = (KEY_BITS == 256) ? 14 : (KEY_BITS == 192) ? 12 : 10;
    localparam logic [IDX_W-1:0] NR_IDX = IDX_W'(NR);
    localparam logic [IDX_W-1:0] NR_M1  = IDX_W'(NR - 1);
    localparam logic [IDX_W-1:0] ONE    = IDX_W'(1);

    if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
        $error("aes_inv_round_engine: KEY_BITS must be 128, 192 or 256");
    end
    if ((2 ** IDX_W) <= NR) begin : g_bad_idx_w
        $error("aes_inv_round_engine: IDX_W too narrow to index round key NR");
    end

    // Inverse S-box, entry x at bits [2047-8x -: 8].
    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    typedef enum logic [1:0] {StIdle, StRound, StFinal, StDone} state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] r_q, r_d;
    logic [127:0]     st_q, st_d;
    logic [127:0]     shifted, subbed, keyed;
    logic             accept;
    logic             in_ready, out_valid;
    logic [IDX_W-1:0] key_idx;

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        return INV_SBOX[2047 - 8 * int'(x) -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Row r rotates right by r: destination column c takes source column c-r.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8 * (4 * c + r) -: 8] = s[127 - 8 * (4 * ((c - r + 4) % 4) + r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int k = 0; k < 16; k++) begin
            o[127 - 8 * k -: 8] = inv_sbox(s[127 - 8 * k -: 8]);
        end
        return o;
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2, x4, x8;
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[31 - 8 * i -: 8];
            x2    = xtime(a[i]);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[i] = x8 ^ a[i];
            mb[i] = x8 ^ x2 ^ a[i];
            md[i] = x8 ^ x4 ^ a[i];
            me[i] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            o[127 - 32 * c -: 32] = inv_mix_col(s[127 - 32 * c -: 32]);
        end
        return o;
    endfunction

    // State register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush overrides every transition.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (bus.in_valid) state_d = StRound;
            StRound: if (r_q == ONE) state_d = StFinal;
            StFinal: state_d = StDone;
            StDone:  if (bus.out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (flush) begin
            state_d = StIdle;
        end
    end

    // Outputs decoded from state and round counter only.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        key_idx   = '0;
        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                key_idx  = NR_IDX;
            end
            StRound: begin
                busy    = 1'b1;
                key_idx = r_q;
            end
            StFinal:  busy = 1'b1;
            StDone:   out_valid = 1'b1;
            default: ;
        endcase
    end

    // in_ready stays high under flush, so accept must exclude flush explicitly.
    assign accept = (state_q == StIdle) && bus.in_valid && !flush;

    always_comb begin
        shifted = inv_shift_rows(st_q);
        subbed  = inv_sub_bytes(shifted);
        keyed   = subbed ^ bus.round_key;
        st_d    = st_q;
        r_d     = r_q;
        if (accept) begin
            st_d = bus.text_in ^ bus.round_key;
            r_d  = NR_M1;
        end else if (state_q == StRound) begin
            st_d = inv_mix_columns(keyed);
            // Counter stops at 1; FINAL uses key 0 without touching r.
            if (r_q != ONE) begin
                r_d = r_q - ONE;
            end
        end else if (state_q == StFinal) begin
            st_d = keyed;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            st_q <= '0;
            r_q  <= '0;
        end else begin
            st_q <= st_d;
            r_q  <= r_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.key_idx   = key_idx;
    assign bus.text_out  = st_q;

endmodule

// File: tb/tb_aes_inv_round_engine.sv
// Bench for aes_inv_round_engine: one engine per key size (128/192/256), each with a
// behavioural key store. Expected plaintexts come from a byte-matrix AES model whose
// S-box tables are derived from GF(2^8) arithmetic at start-up.
module tb_aes_inv_round_engine;

    localparam int NI = 3;
    localparam logic [127:0] PT_FIPS = 128'h00112233445566778899aabbccddeeff;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         flush;
    logic         in_valid  [NI];
    logic [127:0] text_in   [NI];
    logic         out_ready [NI];
    logic         in_ready  [NI];
    logic         out_valid [NI];
    logic [127:0] text_out  [NI];
    logic [3:0]   key_idx   [NI];
    logic         busy      [NI];
    logic [127:0] rk_mem    [NI][16];

    logic [7:0] sbox  [256];
    logic [7:0] isbox [256];

    int n_total = 0;
    int n_bad   = 0;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        aes_inv_round_engine_if #(.IDX_W(4)) bus ();
        assign bus.in_valid  = in_valid[g];
        assign bus.text_in   = text_in[g];
        assign bus.out_ready = out_ready[g];
        assign bus.round_key = rk_mem[g][bus.key_idx];
        assign in_ready[g]   = bus.in_ready;
        assign out_valid[g]  = bus.out_valid;
        assign text_out[g]   = bus.text_out;
        assign key_idx[g]    = bus.key_idx;
        aes_inv_round_engine #(.KEY_BITS(128 + 64 * g), .IDX_W(4)) u_dut (
            .Clk     (clk),
            .Reset_n (rst_n),
            .flush   (flush),
            .bus     (bus.slave),
            .busy    (busy[g])
        );
    end

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    task automatic build_tables();
        logic [7:0] inv;
        logic [7:0] s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++) begin
                if (gmul(8'(x), 8'(b)) == 8'h01) inv = 8'(b);
            end
            s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
            sbox[x]  = s;
            isbox[s] = 8'(x);
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
    endfunction

    // Key bytes are left-aligned in the 256-bit argument.
    task automatic expand_key(input int k, input logic [255:0] key);
        int nk;
        int nr;
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        nk = 4 + 2 * k;
        nr = nk + 6;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32 * i -: 32];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            t = w[i - 1];
            if (i % nk == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
                rc = gmul(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i - nk] ^ t;
        end
        for (int j = 0; j < 16; j++) begin
            if (j <= nr) rk_mem[k][j] = {w[4 * j], w[4 * j + 1], w[4 * j + 2], w[4 * j + 3]};
            else         rk_mem[k][j] = '0;
        end
    endtask

    function automatic logic [127:0] model_dec(input int k, input logic [127:0] ct);
        logic [7:0]   s [4][4];
        logic [7:0]   t [4][4];
        logic [7:0]   coef [4];
        logic [7:0]   acc;
        logic [127:0] rk;
        logic [127:0] o;
        int nr;
        coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        nr   = 10 + 2 * k;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) s[r][c] = ct[127 - 8 * (4 * c + r) -: 8];
        for (int rnd = nr; rnd >= 0; rnd--) begin
            if (rnd != nr) begin
                t = s;
                for (int r = 0; r < 4; r++)
                    for (int c = 0; c < 4; c++) s[r][c] = isbox[t[r][(c - r + 4) % 4]];
            end
            rk = rk_mem[k][rnd];
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) s[r][c] = s[r][c] ^ rk[127 - 8 * (4 * c + r) -: 8];
            if (rnd != nr && rnd != 0) begin
                t = s;
                for (int c = 0; c < 4; c++) begin
                    for (int i = 0; i < 4; i++) begin
                        acc = 8'h00;
                        for (int j = 0; j < 4; j++) acc = acc ^ gmul(t[j][c], coef[(j - i + 4) % 4]);
                        s[i][c] = acc;
                    end
                end
            end
        end
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) o[127 - 8 * (4 * c + r) -: 8] = s[r][c];
        return o;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // ---------------- stimulus tasks ----------------
    // Called at a negedge with the engine idle; returns at a negedge with it idle.
    task automatic run_block(input int k, input logic [255:0] key, input logic [127:0] ct,
                             input int hold, output logic [127:0] got);
        int nr;
        int m;
        logic [127:0] exp;
        logic [3:0] seq [$];
        nr = 10 + 2 * k;
        got = '0;
        expand_key(k, key);
        exp = model_dec(k, ct);
        check_eq("idle key_idx", 128'(key_idx[k]), 128'(nr));
        check_eq("idle in_ready", 128'(in_ready[k]), 128'd1);
        text_in[k]  = ct;
        in_valid[k] = 1'b1;
        @(posedge clk);
        m = 0;
        while (m <= 40) begin
            @(negedge clk);
            in_valid[k] = 1'b0;
            text_in[k]  = rand128();
            if (out_valid[k]) break;
            if (m == 0) begin
                check_eq("busy after accept", 128'(busy[k]), 128'd1);
                check_eq("in_ready while busy", 128'(in_ready[k]), 128'd0);
            end
            seq.push_back(key_idx[k]);
            m++;
        end
        check_eq("latency", 128'(m), 128'(nr));
        if (m != nr) return;
        check_eq("key_idx count", 128'(seq.size()), 128'(nr));
        for (int i = 0; i < seq.size(); i++) check_eq("key_idx seq", 128'(seq[i]), 128'(nr - 1 - i));
        got = text_out[k];
        check_eq("text_out", got, exp);
        // Offer a new block while DONE; it must not be taken.
        in_valid[k] = 1'b1;
        text_in[k]  = ct;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check_eq("hold out_valid", 128'(out_valid[k]), 128'd1);
            check_eq("hold text_out", text_out[k], exp);
            check_eq("hold in_ready", 128'(in_ready[k]), 128'd0);
        end
        out_ready[k] = 1'b1;
        @(negedge clk);
        in_valid[k]  = 1'b0;
        out_ready[k] = 1'b0;
        check_eq("drain out_valid", 128'(out_valid[k]), 128'd0);
        check_eq("no accept in done", 128'(busy[k]), 128'd0);
        check_eq("drain in_ready", 128'(in_ready[k]), 128'd1);
    endtask

    task automatic back_to_back(input int k, input logic [255:0] key,
                                input logic [127:0] ct_a, input logic [127:0] ct_b);
        logic [127:0] exp_a, exp_b;
        logic [127:0] outs [$];
        int acc_cyc [2];
        int n_acc;
        bit pend;
        n_acc = 0;
        pend  = 1'b0;
        acc_cyc = '{0, 0};
        expand_key(k, key);
        exp_a = model_dec(k, ct_a);
        exp_b = model_dec(k, ct_b);
        out_ready[k] = 1'b1;
        in_valid[k]  = 1'b1;
        text_in[k]   = ct_a;
        for (int cyc = 0; cyc < 80 && outs.size() < 2; cyc++) begin
            if (out_valid[k]) outs.push_back(text_out[k]);
            if (pend) begin
                if (n_acc == 1) text_in[k] = ct_b;
                else            in_valid[k] = 1'b0;
                pend = 1'b0;
            end
            if (in_valid[k] && in_ready[k] && n_acc < 2) begin
                acc_cyc[n_acc] = cyc;
                n_acc++;
                pend = 1'b1;
            end
            @(negedge clk);
        end
        in_valid[k]  = 1'b0;
        out_ready[k] = 1'b0;
        check_eq("b2b accepts", 128'(n_acc), 128'd2);
        check_eq("b2b spacing", 128'(acc_cyc[1] - acc_cyc[0]), 128'(12 + 2 * k));
        check_eq("b2b outputs", 128'(outs.size()), 128'd2);
        if (outs.size() == 2) begin
            check_eq("b2b first", outs[0], exp_a);
            check_eq("b2b second", outs[1], exp_b);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached total=%0d bad=%0d", n_total, n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] key128, key192, key256, key;
        logic [127:0] got, ct;
        bit seen;

        key128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
        key192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
        key256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

        rst_n = 1'b0;
        flush = 1'b0;
        for (int k = 0; k < NI; k++) begin
            in_valid[k]  = 1'b0;
            text_in[k]   = '0;
            out_ready[k] = 1'b0;
            for (int j = 0; j < 16; j++) rk_mem[k][j] = '0;
        end
        build_tables();
        #12;
        for (int k = 0; k < NI; k++) begin
            check_eq("reset in_ready", 128'(in_ready[k]), 128'd1);
            check_eq("reset out_valid", 128'(out_valid[k]), 128'd0);
            check_eq("reset busy", 128'(busy[k]), 128'd0);
            check_eq("reset text_out", text_out[k], 128'd0);
            check_eq("reset key_idx", 128'(key_idx[k]), 128'(10 + 2 * k));
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Known-answer vectors; the 128-bit run holds the output for 5 cycles.
        run_block(0, key128, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 5, got);
        check_eq("C.1 plaintext", got, PT_FIPS);
        run_block(1, key192, 128'hdda97ca4864cdfe06eaf70a0ec0d7191, 0, got);
        check_eq("C.2 plaintext", got, PT_FIPS);
        run_block(2, key256, 128'h8ea2b7ca516745bfeafc49904b496089, 2, got);
        check_eq("C.3 plaintext", got, PT_FIPS);

        // Random keys and blocks.
        for (int k = 0; k < NI; k++) begin
            for (int n = 0; n < 4; n++) begin
                key = {rand128(), rand128()};
                run_block(k, key, rand128(), int'($urandom_range(0, 3)), got);
            end
        end

        back_to_back(0, key128, 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                     128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        back_to_back(2, {rand128(), rand128()}, rand128(), rand128());

        // Flush in the middle of the rounds.
        ct = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        expand_key(0, key128);
        text_in[0]  = ct;
        in_valid[0] = 1'b1;
        @(negedge clk);
        in_valid[0] = 1'b0;
        for (int n = 0; n < 20 && key_idx[0] != 4'd5; n++) @(negedge clk);
        check_eq("flush reach r5", 128'(key_idx[0]), 128'd5);
        check_eq("flush busy before", 128'(busy[0]), 128'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check_eq("flush in_ready", 128'(in_ready[0]), 128'd1);
        check_eq("flush busy", 128'(busy[0]), 128'd0);
        check_eq("flush key_idx", 128'(key_idx[0]), 128'd10);
        seen = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (out_valid[0]) seen = 1'b1;
        end
        check_eq("flush no output", 128'(seen), 128'd0);
        // Flush in idle blocks a simultaneous in_valid.
        flush       = 1'b1;
        in_valid[0] = 1'b1;
        @(negedge clk);
        flush       = 1'b0;
        in_valid[0] = 1'b0;
        check_eq("flush idle no accept", 128'(busy[0]), 128'd0);
        run_block(0, key128, ct, 1, got);
        check_eq("after flush plaintext", got, PT_FIPS);

        // Asynchronous reset during FINAL.
        key = {rand128(), rand128()};
        expand_key(1, key);
        text_in[1]  = rand128();
        in_valid[1] = 1'b1;
        @(negedge clk);
        in_valid[1] = 1'b0;
        for (int n = 0; n < 30 && !(busy[1] && key_idx[1] == 4'd0); n++) @(negedge clk);
        check_eq("reach final", 128'(busy[1] && key_idx[1] == 4'd0), 128'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async rst out_valid", 128'(out_valid[1]), 128'd0);
        check_eq("async rst in_ready", 128'(in_ready[1]), 128'd1);
        check_eq("async rst busy", 128'(busy[1]), 128'd0);
        check_eq("async rst text_out", text_out[1], 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (out_valid[1]) seen = 1'b1;
        end
        check_eq("reset no output", 128'(seen), 128'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
